imem_fetch_resp: RTL and testbench

- Responder side of the fetch address stream: accepts PC fetch requests from the PC/fetch stage and issues reads to a fixed-latency synchronous instruction memory.
- Returns instructions tagged with their PC, in order, through a valid/ready interface to decode.
- A credit-limited response FIFO absorbs decode back-pressure.
- A flush (branch/jump redirect) discards every in-flight and buffered response.

---
 rtl/imem_fetch_resp.sv | 125 ++++++++++++
 tb/tb_imem_fetch_resp.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/imem_fetch_resp.sv
// Fetch responder: issues PC reads to a fixed-latency instruction memory and returns
// {pc, instr, misalign} in order through a credit-limited FIFO; flush kills all in-flight work.
module imem_fetch_resp #(
  parameter int XLEN    = 32,
  parameter int MEM_LAT = 1,
  parameter int DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_pc,
  input  logic            flush,
  output logic            mem_rd_en,
  output logic [XLEN-1:0] mem_addr,
  input  logic [31:0]     mem_rdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_pc,
  output logic [31:0]     resp_instr,
  output logic            resp_misalign
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(DEPTH + MEM_LAT + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            misalign;
  } entry_t;

  logic            pipe_vld [MEM_LAT];
  logic [XLEN-1:0] pipe_pc  [MEM_LAT];
  logic            pipe_mis [MEM_LAT];

  entry_t          fifo_mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic [OW-1:0]   outstanding;
  logic            issue;
  logic            misalign_in;
  logic            push;
  logic            pop;
  entry_t          push_entry;
  entry_t          head;

  // Credit covers both reads still in the latency pipe and buffered entries,
  // so a capture always finds a free FIFO slot.
  always_comb begin
    outstanding = OW'(count);
    for (int i = 0; i < MEM_LAT; i++) begin
      outstanding = outstanding + OW'(pipe_vld[i]);
    end
  end

  assign req_ready   = !rst && !flush && (outstanding < OW'(DEPTH));
  assign issue       = req_valid && req_ready;
  assign misalign_in = |req_pc[1:0];
  assign mem_rd_en   = issue && !misalign_in;
  assign mem_addr    = req_pc;

  assign push = pipe_vld[MEM_LAT-1] && !flush;
  assign pop  = resp_valid && resp_ready;

  always_comb begin
    push_entry.pc       = pipe_pc[MEM_LAT-1];
    push_entry.misalign = pipe_mis[MEM_LAT-1];
    push_entry.instr    = pipe_mis[MEM_LAT-1] ? NOP : mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < MEM_LAT; i++) pipe_vld[i] <= 1'b0;
    end else begin
      pipe_vld[0] <= issue;
      for (int i = 1; i < MEM_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_pc[0]  <= req_pc;
    pipe_mis[0] <= misalign_in;
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_pc[i]  <= pipe_pc[i-1];
      pipe_mis[i] <= pipe_mis[i-1];
    end
  end

  // Storage is cleared on reset so head outputs read as zero afterward.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_entry;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head          = fifo_mem[rd_ptr];
  assign resp_valid    = (count != '0);
  assign resp_pc       = head.pc;
  assign resp_instr    = head.instr;
  assign resp_misalign = head.misalign;

endmodule

// File: tb/tb_imem_fetch_resp.sv
// Randomized bench: a transaction-level scoreboard predicts handshakes, credit and
// response timing for imem_fetch_resp, with a delay-line instruction memory model.
module tb_imem_fetch_resp;

  localparam int XLEN    = 32;
  localparam int MEM_LAT = 1;
  localparam int DEPTH   = 4;
  localparam int NCYC    = 3000;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_pc;
  logic            flush;
  logic            mem_rd_en;
  logic [XLEN-1:0] mem_addr;
  logic [31:0]     mem_rdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_pc;
  logic [31:0]     resp_instr;
  logic            resp_misalign;

  imem_fetch_resp #(.XLEN(XLEN), .MEM_LAT(MEM_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .flush(flush),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_pc(resp_pc), .resp_instr(resp_instr), .resp_misalign(resp_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  // Instruction memory: data for a strobed read appears MEM_LAT cycles later;
  // cycles without a read return garbage.
  logic [31:0] rdp [MEM_LAT];
  always @(posedge clk) begin
    rdp[0] <= mem_rd_en ? memf(mem_addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < MEM_LAT; i++) rdp[i] <= rdp[i-1];
  end
  assign mem_rdata = rdp[MEM_LAT-1];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
    int          t;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_bad = 0;
  bit   known = 0;
  bit   after_rst = 0;
  logic [31:0] seq_pc = 32'h0000_0100;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int c);
    logic mis;
    rst = 1'b0; flush = 1'b0;
    if (c < 3) begin
      rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req_pc = '0;
    end else if (c < 40) begin
      req_valid = 1'b1; resp_ready = 1'b1; req_pc = seq_pc; seq_pc = seq_pc + 4;
    end else if (c < 70) begin
      req_valid = 1'b1; resp_ready = 1'b0; req_pc = $urandom() & 32'hFFFF_FFFC;
    end else if (c < 90) begin
      req_valid = 1'b0; resp_ready = 1'b1;
    end else begin
      req_valid  = ($urandom_range(0, 9) < 7);
      resp_ready = ($urandom_range(0, 9) < 6);
      flush      = ($urandom_range(0, 99) < 4);
      rst        = ($urandom_range(0, 99) < 1);
      mis        = ($urandom_range(0, 3) == 0);
      req_pc     = $urandom() & 32'hFFFF_FFFC;
      if (mis) req_pc = req_pc | 32'($urandom_range(1, 3));
    end
  endtask

  task automatic evaluate(input int c);
    bit   exp_rdy, acc, ev;
    exp_t e;
    exp_rdy = !rst && !flush && (q.size() < DEPTH);
    acc     = req_valid && exp_rdy;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("mem_rd_en", 32'(mem_rd_en), 32'(acc && (req_pc[1:0] == 2'b00)));
    if (acc && req_pc[1:0] == 2'b00) chk("mem_addr", mem_addr, req_pc);
    if (known) begin
      ev = (q.size() > 0) && (c >= q[0].t + MEM_LAT + 1);
      chk("resp_valid", 32'(resp_valid), 32'(ev));
      if (ev) begin
        chk("resp_pc", resp_pc, q[0].pc);
        chk("resp_instr", resp_instr, q[0].instr);
        chk("resp_misalign", 32'(resp_misalign), 32'(q[0].mis));
        if (resp_ready) void'(q.pop_front());
      end
      if (after_rst) begin
        chk("rst_resp_pc", resp_pc, 32'h0);
        chk("rst_resp_instr", resp_instr, 32'h0);
        chk("rst_resp_mis", 32'(resp_misalign), 32'h0);
        after_rst = 0;
      end
    end
    if (rst || flush) begin
      q.delete();
    end else if (acc) begin
      e.pc    = req_pc;
      e.mis   = (req_pc[1:0] != 2'b00);
      e.instr = e.mis ? 32'h0000_0013 : memf(req_pc);
      e.t     = c;
      q.push_back(e);
    end
    if (rst) begin
      known = 1;
      after_rst = 1;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_pc = '0; flush = 1'b0; resp_ready = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      drive(c);
      @(negedge clk);
      evaluate(c);
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
